mem_dsram_bridge: RTL and testbench
===================================

// Module: mem_dsram_bridge
// PURPOSE
//  Sits directly after the MEM stage: takes its byte-enable / lane-aligned store data and
//  issues one transaction per access on the SRAM-like data bus (req/addr_ok/data_ok). It
//  stalls the pipeline while the access is in flight and returns sign/zero-extended load
//  data to write-back. It supports one outstanding access, and handles flushes mid-transaction.
// PARAMETERS
//  ADDR_MASK      32'h1FFF_FFFF  AND-mask applied to the virtual address to form data_addr
//  TIMEOUT_CYCLES 255            max cycles in REQ+WAIT before abort (DSRAM_TIMEOUT_EN only)
// PORTS
//  clk           in   1   clock
//  rst           in   1   asynchronous, active-high reset
//  acc_valid     in   1   MEM stage holds a load/store with no exception (pre-gated upstream)
//  acc_we        in   4   byte enables from MEM; 0 = load
//  acc_wdata     in   32  store data, already placed on byte lanes
//  acc_addr      in   32  byte address (ALU result)
//  acc_type      in   3   [1:0] 00 byte/01 half/10 word; [2] 1 = zero-extend load
//  flush         in   1   exception/redirect; kill the current access
//  mem_stall     out  1   hold IF..MEM this cycle
//  load_valid    out  1   load_data valid (1 cycle)
//  load_data     out  32  extended load result
//  bus_err       out  1   timeout abort pulse (0 when DSRAM_TIMEOUT_EN is not defined)
//  data_req      out  1   bus request
//  data_wr       out  1   1 = write
//  data_size     out  2   = acc_type[1:0]
//  data_addr     out  32  acc_addr & ADDR_MASK
//  data_wstrb    out  4   = acc_we
//  data_wdata    out  32  = acc_wdata
//  data_addr_ok  in   1   slave accepted the request
//  data_data_ok  in   1   write done / rdata valid
//  data_rdata    in   32  read data, full word
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; latched regs 0; discard=0. The in-flight bus
//   transaction is abandoned.
//  IDLE: mem_stall = acc_valid & ~flush (combinational, same cycle). On that condition,
//   latch addr/we/wdata/type and go to REQ.
//  REQ: data_req=1, with all bus outputs driven from latches and held stable.
//   addr_ok & data_ok same cycle -> DONE; addr_ok -> WAIT; flush & ~addr_ok -> IDLE (req dropped).
//  WAIT: data_req=0. If flush arrives, set discard. On data_ok: discard ? IDLE (clear discard) : DONE.
//  DONE: exactly 1 cycle; mem_stall=0, so the pipeline advances on this edge.
//   load_valid = ~data_wr; then go to IDLE unconditionally.
//  mem_stall=1 in REQ and WAIT. mem_stall=0 in DONE, and also when the access is being discarded.
//  Flush in DONE: ignored; the result is already committed.
//  Load extension: capture data_rdata on data_ok. Byte lane = addr[1:0]; half lane = addr[1].
//   Byte/half results are sign-extended, or zero-extended when type[2]=1. Word results pass unchanged.
//   load_data holds its value until the next DONE.
//  data_wr = |we (latched). A store with we=0 is treated as a read; this never occurs when
//   the stage is gated correctly.
// CONFIGURATION
//  DSRAM_TIMEOUT_EN defined: an 8+ bit counter is cleared on entry to REQ and counts in REQ/WAIT.
//   When count reaches TIMEOUT_CYCLES: bus_err=1 for one cycle, state goes to IDLE, mem_stall
//   drops, load_valid=0.
//  DSRAM_TIMEOUT_EN undefined: no counter; bus_err is tied to 0; the bridge waits forever.
// TESTING
//  lb @0x8000_0003, acc_type=000, rdata=0x80FF_1234, addr_ok+1 cycle, data_ok+2 cycles
//   -> data_addr=0x0000_0003, load_data=0xFFFF_FF80, stall 3 cycles.
//  lhu @0x0000_0002, acc_type=101, rdata=0xBEEF_0000 -> load_data=0x0000_BEEF.
//  sw, we=1111, wdata=0x1234_5678; addr_ok and data_ok in the first REQ cycle
//   -> data_wr=1, wstrb=1111, DONE next cycle, load_valid=0.
//  flush in WAIT, then data_ok 3 cycles later -> no load_valid, return to IDLE;
//   next access issues cleanly.
//  flush in REQ with addr_ok=0 -> data_req drops the next cycle; no data_ok expected.
//  DSRAM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no addr_ok -> bus_err pulse on cycle 4, stall released;
//   async rst mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/mem_dsram_bridge.sv
// MEM-stage to SRAM-like data bus bridge: one outstanding access, pipeline stall, load extension.
// Optional bus timeout abort enabled by defining DSRAM_TIMEOUT_EN.
module mem_dsram_bridge #(
   parameter logic [31:0] ADDR_MASK      = 32'h1FFF_FFFF,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        acc_valid,
   input  logic [3:0]  acc_we,
   input  logic [31:0] acc_wdata,
   input  logic [31:0] acc_addr,
   input  logic [2:0]  acc_type,
   input  logic        flush,
   output logic        mem_stall,
   output logic        load_valid,
   output logic [31:0] load_data,
   output logic        bus_err,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  we_q, we_d;
   logic [2:0]  type_q, type_d;
   logic [31:0] load_q, load_d;
   logic        discard_q, discard_d;
   logic        timeout;
   logic        abort;
   logic [31:0] ext_data;

   function automatic logic [31:0] extend(input logic [31:0] rd, input logic [1:0] lane,
                                          input logic [2:0] typ);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[{lane, 3'b000} +: 8];
      h = lane[1] ? rd[31:16] : rd[15:0];
      case (typ[1:0])
         2'b00:   extend = typ[2] ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   extend = typ[2] ? {16'h0, h} : {{16{h[15]}}, h};
         default: extend = rd;
      endcase
   endfunction

   assign ext_data = extend(data_rdata, addr_q[1:0], type_q);

`ifdef DSRAM_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CW-1:0] cnt_q;

   // Zero on every REQ entry because it is held clear outside REQ/WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                       cnt_q <= '0;
      else if (state_q == S_REQ || state_q == S_WAIT) cnt_q <= cnt_q + CW'(1);
      else                                           cnt_q <= '0;
   end

   assign timeout = (state_q == S_REQ || state_q == S_WAIT) &&
                    (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
   localparam int unsigned timeout_unused = TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   // Bus handshake: data_req is held with stable addr/wr/size/wstrb/wdata until data_addr_ok
   // accepts the request; data_data_ok completes it (same cycle or later). One access in flight.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      type_d     = type_q;
      load_d     = load_q;
      discard_d  = discard_q;
      mem_stall  = 1'b0;
      data_req   = 1'b0;
      load_valid = 1'b0;
      abort      = 1'b0;
      case (state_q)
         S_IDLE: begin
            mem_stall = acc_valid & ~flush;
            if (acc_valid && !flush) begin
               addr_d  = acc_addr;
               we_d    = acc_we;
               wdata_d = acc_wdata;
               type_d  = acc_type;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            data_req  = 1'b1;
            mem_stall = ~flush;
            if (data_addr_ok && data_data_ok) begin
               if (flush) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
                  if (!data_wr) load_d = ext_data;
               end
            end else if (flush && !data_addr_ok) begin
               state_d = S_IDLE;
            end else if (timeout) begin
               abort     = 1'b1;
               mem_stall = 1'b0;
               state_d   = S_IDLE;
            end else if (data_addr_ok) begin
               discard_d = flush;
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            // A discarded access no longer holds the pipeline, but a new access must wait for us.
            mem_stall = (discard_q | flush) ? (acc_valid & ~flush) : 1'b1;
            if (data_data_ok) begin
               discard_d = 1'b0;
               if (discard_q || flush) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
                  if (!data_wr) load_d = ext_data;
               end
            end else if (timeout) begin
               abort     = 1'b1;
               mem_stall = 1'b0;
               discard_d = 1'b0;
               state_d   = S_IDLE;
            end else if (flush) begin
               discard_d = 1'b1;
            end
         end
         S_DONE: begin
            load_valid = ~data_wr;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= '0;
         type_q    <= '0;
         load_q    <= '0;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         type_q    <= type_d;
         load_q    <= load_d;
         discard_q <= discard_d;
      end
   end

   assign bus_err    = abort;
   assign data_wr    = |we_q;
   assign data_size  = type_q[1:0];
   assign data_addr  = addr_q & ADDR_MASK;
   assign data_wstrb = we_q;
   assign data_wdata = wdata_q;
   assign load_data  = load_q;

endmodule

// File: tb/tb_mem_dsram_bridge.sv
// Directed bench for mem_dsram_bridge: load/store transactions, flushes, async reset, timeout.
module tb_mem_dsram_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        acc_valid;
   logic [3:0]  acc_we;
   logic [31:0] acc_wdata;
   logic [31:0] acc_addr;
   logic [2:0]  acc_type;
   logic        flush;
   logic        mem_stall;
   logic        load_valid;
   logic [31:0] load_data;
   logic        bus_err;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   logic [31:0] req_addr;
   logic        req_wr;
   logic [1:0]  req_size;
   logic [3:0]  req_wstrb;
   logic [31:0] req_wdata;

   mem_dsram_bridge #(.ADDR_MASK(32'h1FFF_FFFF), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .acc_valid(acc_valid), .acc_we(acc_we), .acc_wdata(acc_wdata),
      .acc_addr(acc_addr), .acc_type(acc_type), .flush(flush),
      .mem_stall(mem_stall), .load_valid(load_valid), .load_data(load_data),
      .bus_err(bus_err), .data_req(data_req), .data_wr(data_wr),
      .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: each load_valid pops the next expected load result
   always @(negedge clk) begin
      if (!rst && load_valid) begin
         if (exp_q.size() == 0) begin
            check("load_valid_unexpected", {31'h0, load_valid}, 32'h0);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("load_data", load_data, e);
         end
      end
`ifndef DSRAM_TIMEOUT_EN
      if (!rst) check("bus_err_tied", {31'h0, bus_err}, 32'h0);
`endif
   end

   // Driver: present an access, answer addr_ok after aok_dly extra REQ cycles, data_ok
   // dok_dly cycles after addr_ok (0 = same cycle). Returns in the DONE cycle.
   task automatic do_access(input logic [31:0] addr, input logic [3:0] we,
                            input logic [31:0] wdata, input logic [2:0] typ,
                            input int aok_dly, input int dok_dly,
                            input logic [31:0] rdata, output int stall_cnt);
      stall_cnt = 0;
      acc_valid = 1'b1;
      acc_we    = we;
      acc_wdata = wdata;
      acc_addr  = addr;
      acc_type  = typ;
      @(negedge clk);
      stall_cnt += int'(mem_stall);
      tick();
      acc_valid = 1'b0;
      for (int i = 0; i <= aok_dly; i++) begin
         if (i == aok_dly) begin
            data_addr_ok = 1'b1;
            if (dok_dly == 0) begin
               data_data_ok = 1'b1;
               data_rdata   = rdata;
            end
         end
         @(negedge clk);
         stall_cnt += int'(mem_stall);
         if (i == 0) begin
            req_addr  = data_addr;
            req_wr    = data_wr;
            req_size  = data_size;
            req_wstrb = data_wstrb;
            req_wdata = data_wdata;
         end
         check("req_held", {31'h0, data_req}, 32'h1);
         tick();
      end
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      for (int i = 1; i <= dok_dly; i++) begin
         if (i == dok_dly) begin
            data_data_ok = 1'b1;
            data_rdata   = rdata;
         end
         @(negedge clk);
         stall_cnt += int'(mem_stall);
         check("wait_req_low", {31'h0, data_req}, 32'h0);
         tick();
      end
      data_data_ok = 1'b0;
   endtask

   task automatic done_cycle(input logic lv);
      @(negedge clk);
      check("done_stall", {31'h0, mem_stall}, 32'h0);
      check("done_load_valid", {31'h0, load_valid}, {31'h0, lv});
      tick();
   endtask

   initial begin
      int st;
      rst          = 1'b1;
      acc_valid    = 1'b0;
      acc_we       = '0;
      acc_wdata    = '0;
      acc_addr     = '0;
      acc_type     = '0;
      flush        = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = '0;

      @(negedge clk);
      check("rst_req", {31'h0, data_req}, 32'h0);
      check("rst_stall", {31'h0, mem_stall}, 32'h0);
      check("rst_load_valid", {31'h0, load_valid}, 32'h0);
      check("rst_load_data", load_data, 32'h0);
      check("rst_addr", data_addr, 32'h0);
      check("rst_wr", {31'h0, data_wr}, 32'h0);
      check("rst_wstrb", {28'h0, data_wstrb}, 32'h0);
      check("rst_wdata", data_wdata, 32'h0);
      check("rst_size", {30'h0, data_size}, 32'h0);
      check("rst_bus_err", {31'h0, bus_err}, 32'h0);
      tick();
      rst = 1'b0;
      tick();

      // lb sign-extended, top byte lane, masked address
      exp_q.push_back(32'hFFFF_FF80);
      do_access(32'h8000_0003, 4'h0, 32'h0, 3'b000, 0, 1, 32'h80FF_1234, st);
      check("lb_addr", req_addr, 32'h0000_0003);
      check("lb_wr", {31'h0, req_wr}, 32'h0);
      check("lb_size", {30'h0, req_size}, 32'h0);
      check("lb_stall", st, 3);
      done_cycle(1'b1);
      @(negedge clk);
      check("lb_hold", load_data, 32'hFFFF_FF80);
      tick();

      // lhu upper half
      exp_q.push_back(32'h0000_BEEF);
      do_access(32'h0000_0002, 4'h0, 32'h0, 3'b101, 0, 1, 32'hBEEF_0000, st);
      check("lhu_size", {30'h0, req_size}, 32'h1);
      check("lhu_stall", st, 3);
      done_cycle(1'b1);

      // sw with addr_ok and data_ok in the first REQ cycle
      do_access(32'h8000_1000, 4'hF, 32'h1234_5678, 3'b010, 0, 0, 32'h0, st);
      check("sw_wr", {31'h0, req_wr}, 32'h1);
      check("sw_wstrb", {28'h0, req_wstrb}, 32'hF);
      check("sw_wdata", req_wdata, 32'h1234_5678);
      check("sw_addr", req_addr, 32'h0000_1000);
      check("sw_stall", st, 2);
      done_cycle(1'b0);

      // lw, slave delays addr_ok two cycles
      exp_q.push_back(32'hDEAD_BEEF);
      do_access(32'h9000_0004, 4'h0, 32'h0, 3'b010, 2, 0, 32'hDEAD_BEEF, st);
      check("lw_addr", req_addr, 32'h1000_0004);
      check("lw_stall", st, 4);
      done_cycle(1'b1);

      // lh sign-extended, lower half, longer WAIT
      exp_q.push_back(32'hFFFF_8001);
      do_access(32'h0000_0000, 4'h0, 32'h0, 3'b001, 1, 2, 32'h1234_8001, st);
      check("lh_stall", st, 5);
      done_cycle(1'b1);

      // flush in WAIT, data_ok three cycles later must be discarded
      acc_valid = 1'b1; acc_we = 4'h0; acc_addr = 32'h40; acc_type = 3'b010;
      @(negedge clk);
      tick();
      acc_valid    = 1'b0;
      data_addr_ok = 1'b1;
      @(negedge clk);
      tick();
      data_addr_ok = 1'b0;
      flush        = 1'b1;
      @(negedge clk);
      check("wflush_stall", {31'h0, mem_stall}, 32'h0);
      check("wflush_req", {31'h0, data_req}, 32'h0);
      tick();
      flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("wflush_no_lv", {31'h0, load_valid}, 32'h0);
         tick();
      end
      data_data_ok = 1'b1;
      data_rdata   = 32'hFFFF_FFFF;
      @(negedge clk);
      tick();
      data_data_ok = 1'b0;
      @(negedge clk);
      check("wflush_after_lv", {31'h0, load_valid}, 32'h0);
      check("wflush_after_stall", {31'h0, mem_stall}, 32'h0);
      check("wflush_after_req", {31'h0, data_req}, 32'h0);
      check("wflush_hold", load_data, 32'hFFFF_8001);
      tick();

      // next access after discard: lbu byte lane 1
      exp_q.push_back(32'h0000_00AB);
      do_access(32'h0000_0001, 4'h0, 32'h0, 3'b100, 0, 1, 32'h0000_AB00, st);
      check("lbu_stall", st, 3);
      done_cycle(1'b1);

      // flush in REQ without addr_ok drops the request
      acc_valid = 1'b1; acc_we = 4'h0; acc_addr = 32'h80; acc_type = 3'b010;
      @(negedge clk);
      tick();
      acc_valid = 1'b0;
      flush     = 1'b1;
      @(negedge clk);
      check("rflush_req", {31'h0, data_req}, 32'h1);
      check("rflush_stall", {31'h0, mem_stall}, 32'h0);
      tick();
      flush = 1'b0;
      @(negedge clk);
      check("rflush_req_drop", {31'h0, data_req}, 32'h0);
      check("rflush_stall_idle", {31'h0, mem_stall}, 32'h0);
      tick();

      // sh afterwards issues cleanly
      do_access(32'h0000_0100, 4'h3, 32'h0000_5555, 3'b001, 0, 0, 32'h0, st);
      check("sh_wstrb", {28'h0, req_wstrb}, 32'h3);
      check("sh_wr", {31'h0, req_wr}, 32'h1);
      check("sh_addr", req_addr, 32'h0000_0100);
      check("sh_stall", st, 2);
      done_cycle(1'b0);

`ifdef DSRAM_TIMEOUT_EN
      // no addr_ok: abort on the 4th REQ cycle
      acc_valid = 1'b1; acc_we = 4'h0; acc_addr = 32'h10; acc_type = 3'b010;
      @(negedge clk);
      tick();
      acc_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("to_no_err", {31'h0, bus_err}, 32'h0);
         check("to_req", {31'h0, data_req}, 32'h1);
         tick();
      end
      @(negedge clk);
      check("to_err", {31'h0, bus_err}, 32'h1);
      check("to_stall", {31'h0, mem_stall}, 32'h0);
      check("to_lv", {31'h0, load_valid}, 32'h0);
      tick();
      @(negedge clk);
      check("to_err_pulse", {31'h0, bus_err}, 32'h0);
      check("to_idle_req", {31'h0, data_req}, 32'h0);
      tick();
`else
      // without the timeout the bridge keeps waiting past any limit
      exp_q.push_back(32'h0BAD_F00D);
      acc_valid = 1'b1; acc_we = 4'h0; acc_addr = 32'h20; acc_type = 3'b010;
      @(negedge clk);
      tick();
      acc_valid = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         check("nto_req", {31'h0, data_req}, 32'h1);
         check("nto_stall", {31'h0, mem_stall}, 32'h1);
         tick();
      end
      data_addr_ok = 1'b1;
      data_data_ok = 1'b1;
      data_rdata   = 32'h0BAD_F00D;
      @(negedge clk);
      tick();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      done_cycle(1'b1);
`endif

      // async reset mid-WAIT clears outputs immediately
      acc_valid = 1'b1; acc_we = 4'h4; acc_wdata = 32'h00AA_0000;
      acc_addr = 32'h0000_0002; acc_type = 3'b000;
      @(negedge clk);
      tick();
      acc_valid    = 1'b0;
      data_addr_ok = 1'b1;
      @(negedge clk);
      check("arst_pre_wstrb", {28'h0, data_wstrb}, 32'h4);
      tick();
      data_addr_ok = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst_req", {31'h0, data_req}, 32'h0);
      check("arst_stall", {31'h0, mem_stall}, 32'h0);
      check("arst_wr", {31'h0, data_wr}, 32'h0);
      check("arst_wstrb", {28'h0, data_wstrb}, 32'h0);
      check("arst_wdata", data_wdata, 32'h0);
      check("arst_addr", data_addr, 32'h0);
      check("arst_load_data", load_data, 32'h0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("arst_idle_req", {31'h0, data_req}, 32'h0);
      tick();

      // recovery load
      exp_q.push_back(32'h0000_007F);
      do_access(32'h0000_0000, 4'h0, 32'h0, 3'b000, 0, 1, 32'h0000_007F, st);
      check("rec_stall", st, 3);
      done_cycle(1'b1);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
